alu_shifter36: RTL and testbench

ALU_SHIFTER36 -- requirements
Module: alu_shifter36

---
 rtl/shifter_pkg.sv | 29 ++
 rtl/mc10141.sv | 37 +++
 rtl/alu_shifter36.sv | 106 ++++++++++
 tb/tb_alu_shifter36.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared constants and enums for the 36-bit ALU result shifter.
package shifter_pkg;

    localparam int unsigned Width    = 36;
    localparam int unsigned SliceW   = 4;
    localparam int unsigned Slices   = Width / SliceW;
    localparam int unsigned CntWidth = 6;

    // Encoding 2'b11 is reserved and decodes as LOGICAL.
    typedef enum logic [1:0] {
        LOGICAL = 2'b00,
        ARITH   = 2'b01,
        ROTATE  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SelHold  = 2'b00,
        SelLeft  = 2'b01,
        SelRight = 2'b10,
        SelLoad  = 2'b11
    } sel_e;

endpackage

// File: rtl/mc10141.sv
// 4-bit universal shift register slice; bit 0 is the MSB, "left" moves toward bit 0.
module mc10141
    import shifter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  sel_e       sel_i,
    input  logic [0:3] d_i,
    input  logic       sin_l_i,
    input  logic       sin_r_i,
    output logic [0:3] q_o
);

    logic [0:3] q_d, q_q;

    // sin_l_i enters bit 0 on a right shift; sin_r_i enters bit 3 on a left shift.
    always_comb begin
        q_d = q_q;
        unique case (sel_i)
            SelHold:  q_d = q_q;
            SelLeft:  q_d = {q_q[1:3], sin_r_i};
            SelRight: q_d = {sin_l_i, q_q[0:2]};
            SelLoad:  q_d = d_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/alu_shifter36.sv
// Multi-cycle 36-bit shifter: FSM and shift counter driving a chain of nine mc10141 slices.
module alu_shifter36
    import shifter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [0:35]  f,
    input  logic         load,
    input  logic         start,
    input  logic [0:5]   count,
    input  logic         dir,
    input  logic [0:1]   mode,
    output logic [0:35]  q,
    output logic         busy,
    output logic         done
);

    state_e                state_d, state_q;
    logic [CntWidth-1:0]   cnt_d, cnt_q;
    logic                  dir_d, dir_q;
    logic [1:0]            mode_d, mode_q;
    sel_e                  sel;

    logic [0:Width-1]      q_w;
    logic [0:Slices-1]     sin_l, sin_r;
    logic                  rot, arith, fill_left, fill_right;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        sel     = SelHold;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    sel = SelLoad;
                end
                if (start) begin
                    cnt_d   = count;
                    dir_d   = dir;
                    mode_d  = mode;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    sel   = dir_q ? SelRight : SelLeft;
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign rot        = (mode_q == ROTATE);
    assign arith      = (mode_q == ARITH);
    assign fill_left  = rot ? q_w[0] : 1'b0;
    assign fill_right = rot ? q_w[Width-1] : (arith ? q_w[0] : 1'b0);

    // Slice k holds q[4k..4k+3]; neighbours feed each other's serial inputs.
    for (genvar k = 0; k < Slices; k++) begin : g_slice
        if (k == 0) begin : g_first
            assign sin_l[k] = fill_right;
        end else begin : g_chain_l
            assign sin_l[k] = q_w[4*k-1];
        end
        if (k == Slices - 1) begin : g_last
            assign sin_r[k] = fill_left;
        end else begin : g_chain_r
            assign sin_r[k] = q_w[4*k+4];
        end

        mc10141 u_slice (
            .clk_i   (clk),
            .rst_i   (rst),
            .sel_i   (sel),
            .d_i     (f[4*k +: 4]),
            .sin_l_i (sin_l[k]),
            .sin_r_i (sin_r[k]),
            .q_o     (q_w[4*k +: 4])
        );
    end

    assign q    = q_w;
    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_alu_shifter36.sv
// Scoreboard bench for alu_shifter36: expected q queued at start, popped at done.
module tb_alu_shifter36;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:35] f;
    logic        load, start, dir;
    logic [0:5]  count;
    logic [0:1]  mode;
    logic [0:35] q;
    logic        busy, done;

    int nvec  = 0;
    int nfail = 0;
    logic [0:35] model_q;
    logic [0:35] exp_q[$];

    alu_shifter36 dut (
        .clk   (clk),
        .rst   (rst),
        .f     (f),
        .load  (load),
        .start (start),
        .count (count),
        .dir   (dir),
        .mode  (mode),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [0:35] shift_model(input logic [0:35] v, input int n,
                                                input logic d, input logic [1:0] m);
        logic fill;
        for (int i = 0; i < n; i++) begin
            if (!d) begin
                fill = (m == 2'd2) ? v[0] : 1'b0;
                v = {v[1:35], fill};
            end else begin
                fill = (m == 2'd2) ? v[35] : ((m == 2'd1) ? v[0] : 1'b0);
                v = {fill, v[0:34]};
            end
        end
        return v;
    endfunction

    // Drives one operation and records what the DUT did; i counts negedges after the start edge.
    task automatic do_op(input logic [0:35] fv, input logic ld, input int cnt, input logic d,
                         input logic [1:0] m, input int poke_at, input int rst_at,
                         output int busy_cycles, output int done_at, output int pulses,
                         output logic [0:35] q_at);
        @(negedge clk);
        f = fv; load = ld; start = 1'b1; count = 6'(cnt); dir = d; mode = m;
        if (ld) model_q = fv;
        model_q = shift_model(model_q, cnt, d, m);
        exp_q.push_back(model_q);
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        busy_cycles = 0; done_at = -1; pulses = 0; q_at = 'x;
        for (int i = 1; i <= 100; i++) begin
            if (busy) busy_cycles++;
            if (done) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = i;
                    q_at = q;
                end
            end
            if (done_at >= 0 && i > done_at + 1) break;
            if (poke_at == i) begin
                load = 1'b1; start = 1'b1; f = ~fv;
            end else if (poke_at + 1 == i) begin
                load = 1'b0; start = 1'b0;
            end
            if (rst_at == i) rst = 1'b1;
            else if (rst_at > 0 && rst_at + 1 == i) rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; start = 1'b0; f = '0; count = '0; dir = 1'b0; mode = '0;
        repeat (2) @(negedge clk);
        nvec++; if (q !== 36'o0) begin nfail++; $display("FAIL reset_q: got %o want 0", q); end
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b want 0", done); end
        load = 1'b1; start = 1'b1; f = 36'o777000777000; count = 6'd5;
        @(negedge clk);
        nvec++; if (q !== 36'o0) begin nfail++; $display("FAIL rst_over_load: got %o want 0", q); end
        rst = 1'b0; load = 1'b0; start = 1'b0;
        @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_over_start: busy %b want 0", busy); end
        model_q = '0;
    endtask

    task automatic test_logical_left();
        int bc, da, np; logic [0:35] qa, e;
        do_op(36'o400000000001, 1'b1, 1, 1'b0, 2'b00, 0, 0, bc, da, np, qa);
        e = exp_q.pop_front();
        nvec++; if (qa !== e) begin nfail++; $display("FAIL lsl_model: got %o want %o", qa, e); end
        nvec++; if (qa !== 36'o000000000002) begin nfail++; $display("FAIL lsl_q: got %o want 2", qa); end
        nvec++; if (da !== 3) begin nfail++; $display("FAIL lsl_done_cycle: got %0d want 3", da); end
        nvec++; if (np !== 1) begin nfail++; $display("FAIL lsl_done_pulses: got %0d want 1", np); end
    endtask

    task automatic test_arith_right();
        int bc, da, np; logic [0:35] qa, e;
        do_op(36'o400000000000, 1'b1, 3, 1'b1, 2'b01, 0, 0, bc, da, np, qa);
        e = exp_q.pop_front();
        nvec++; if (qa !== e) begin nfail++; $display("FAIL asr_model: got %o want %o", qa, e); end
        nvec++; if (qa !== 36'o740000000000) begin nfail++; $display("FAIL asr_q: got %o want 740000000000", qa); end
        nvec++; if (bc !== 4) begin nfail++; $display("FAIL asr_busy_cycles: got %0d want 4", bc); end
        nvec++; if (da !== 5) begin nfail++; $display("FAIL asr_done_cycle: got %0d want 5", da); end
    endtask

    task automatic test_rotate();
        int bc, da, np; logic [0:35] qa, e;
        do_op(36'o123456701234, 1'b1, 3, 1'b0, 2'b10, 0, 0, bc, da, np, qa);
        e = exp_q.pop_front();
        nvec++; if (qa !== e) begin nfail++; $display("FAIL rol_model: got %o want %o", qa, e); end
        nvec++; if (qa !== 36'o234567012341) begin nfail++; $display("FAIL rol_q: got %o want 234567012341", qa); end
    endtask

    task automatic test_load_start_same();
        int bc, da, np; logic [0:35] qa, e;
        do_op(36'o000000000017, 1'b1, 0, 1'b0, 2'b00, 0, 0, bc, da, np, qa);
        e = exp_q.pop_front();
        nvec++; if (qa !== 36'o17) begin nfail++; $display("FAIL cnt0_q: got %o want %o", qa, e); end
        nvec++; if (da !== 2) begin nfail++; $display("FAIL cnt0_done_cycle: got %0d want 2", da); end
        nvec++; if (bc !== 1) begin nfail++; $display("FAIL cnt0_busy_cycles: got %0d want 1", bc); end
    endtask

    task automatic test_load_during_shift();
        int bc, da, np; logic [0:35] qa, e;
        do_op(36'o135724613572, 1'b1, 5, 1'b1, 2'b00, 2, 0, bc, da, np, qa);
        e = exp_q.pop_front();
        nvec++; if (qa !== e) begin nfail++; $display("FAIL load_in_shift_q: got %o want %o", qa, e); end
        nvec++; if (da !== 7) begin nfail++; $display("FAIL load_in_shift_done: got %0d want 7", da); end
        nvec++; if (np !== 1) begin nfail++; $display("FAIL load_in_shift_pulses: got %0d want 1", np); end
    endtask

    task automatic test_rst_mid_shift();
        int bc, da, np; logic [0:35] qa, e;
        do_op(36'o777777777777, 1'b1, 10, 1'b0, 2'b10, 0, 2, bc, da, np, qa);
        e = exp_q.pop_back();
        model_q = '0;
        nvec++; if (np !== 0) begin nfail++; $display("FAIL rst_abort_pulses: got %0d want 0", np); end
        nvec++; if (q !== 36'o0) begin nfail++; $display("FAIL rst_abort_q: got %o want 0", q); end
        nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_abort_busy: got %b want 0", busy); end
        nvec++; if (bc !== 2) begin nfail++; $display("FAIL rst_abort_busy_cycles: got %0d want 2", bc); end
    endtask

    task automatic test_boundaries();
        int bc, da, np; logic [0:35] qa, e;
        logic [0:35] fs[5] = '{36'o777777777777, 36'o400000000001, 36'o123456701234,
                               36'o400000000000, 36'o543210765432};
        int          cs[5] = '{40, 37, 37, 63, 36};
        logic        ds[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  ms[5] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
        for (int k = 0; k < 5; k++) begin
            do_op(fs[k], 1'b1, cs[k], ds[k], ms[k], 0, 0, bc, da, np, qa);
            e = exp_q.pop_front();
            nvec++; if (qa !== e) begin nfail++; $display("FAIL boundary%0d_q: got %o want %o", k, qa, e); end
            nvec++; if (da !== cs[k] + 2) begin nfail++; $display("FAIL boundary%0d_done: got %0d want %0d", k, da, cs[k] + 2); end
        end
    endtask

    task automatic test_back_to_back();
        int bc, da, np; logic [0:35] qa, e;
        for (int k = 0; k < 12; k++) begin
            do_op({$urandom(), 4'($urandom())}, (k % 3 == 0), $urandom_range(0, 45),
                  1'($urandom()), 2'($urandom_range(0, 3)), 0, 0, bc, da, np, qa);
            e = exp_q.pop_front();
            nvec++; if (qa !== e) begin nfail++; $display("FAIL chain%0d_q: got %o want %o", k, qa, e); end
            nvec++; if (np !== 1) begin nfail++; $display("FAIL chain%0d_pulses: got %0d want 1", k, np); end
        end
    endtask

    initial begin
        test_reset();
        test_logical_left();
        test_arith_right();
        test_rotate();
        test_load_start_same();
        test_load_during_shift();
        test_rst_mid_shift();
        test_boundaries();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
